// File: rtl/memory_writer_fsm.sv
// ---------------------------------------------------------------------------
// memory_writer_fsm
//
// Purpose:
//   Each press of the active-low "advance" pushbutton writes one block of
//   WORDS pattern words into a synchronous RAM port. Word i of a pass holds
//   {pass_count[7:0], i[7:0]}, resized to DATA_WIDTH.
//
//   With READBACK_CHECK_EN defined, every word is read back after the pass
//   and compared with the pattern. A mismatch sets a sticky error flag and
//   bumps a saturating error counter. Without the macro, WRITE goes
//   straight to DONE and mem_rdata is not used.
//
//   Progress is shown on 10 LEDs. The pass count and the error count are
//   shown as two hex digits each on the 7-segment pairs.
//
// Optional feature macro: READBACK_CHECK_EN
//
// Ports:
//   clk               in   system clock
//   reset             in   asynchronous, active-high reset
//   advance           in   raw pushbutton, active-low, idle high
//   mem_addr          out  RAM address (BASE_ADDR + index, wraps)
//   mem_wdata         out  RAM write data
//   mem_we            out  RAM write enable
//   mem_rdata         in   RAM read data, READ_LATENCY cycles after address
//   leds              out  [0] busy, [1] done, [2] error, [3] we, [9:4] index
//   left_7_seg_pair   out  pass_count as two digits, active-low segments
//   right_7_seg_pair  out  error_count as two digits, active-low segments
// ---------------------------------------------------------------------------
module memory_writer_fsm #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int BASE_ADDR    = 0,
  parameter int WORDS        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [9:0]            leds,
  output logic [13:0]           left_7_seg_pair,
  output logic [13:0]           right_7_seg_pair
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_WAIT = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [5:0] LAST_IDX  = 6'(WORDS - 1);
  // RD_WAIT lasts READ_LATENCY-1 cycles, so the counter is loaded with one less
  localparam logic [1:0] WAIT_LOAD = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  // Pattern word for a given pass and index, zero-extended or truncated
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [7:0] pc,
                                                      input logic [5:0] idx);
    logic [15:0] w_word;
    w_word = {pc, 2'b00, idx};
    return DATA_WIDTH'(w_word);
  endfunction

  // Hex digit to active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] f_seg(input logic [3:0] h);
    logic [6:0] w_s;
    case (h)
      4'h0:    w_s = 7'h40;
      4'h1:    w_s = 7'h79;
      4'h2:    w_s = 7'h24;
      4'h3:    w_s = 7'h30;
      4'h4:    w_s = 7'h19;
      4'h5:    w_s = 7'h12;
      4'h6:    w_s = 7'h02;
      4'h7:    w_s = 7'h78;
      4'h8:    w_s = 7'h00;
      4'h9:    w_s = 7'h10;
      4'hA:    w_s = 7'h08;
      4'hB:    w_s = 7'h03;
      4'hC:    w_s = 7'h46;
      4'hD:    w_s = 7'h21;
      4'hE:    w_s = 7'h06;
      4'hF:    w_s = 7'h0E;
      default: w_s = 7'h7F;
    endcase
    return w_s;
  endfunction

  // Button conditioning
  logic r_sync1, r_sync2, r_sync3, r_press;
  logic w_fall;

  // FSM state and datapath registers
  state_t      r_state;
  logic [5:0]  r_idx;
  logic [1:0]  r_wait;
  logic [7:0]  r_pass;
  logic [7:0]  r_err_cnt;
  logic        r_err_flag;
  logic        r_done;

  // Next-state values
  state_t      w_state_nxt;
  logic [5:0]  w_idx_nxt;
  logic [1:0]  w_wait_nxt;
  logic [7:0]  w_pass_nxt;
  logic [7:0]  w_err_cnt_nxt;
  logic        w_err_flag_nxt;
  logic        w_done_nxt;
  logic        w_we_nxt;
  logic        w_rd_ok;

  // Registered outputs
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_we;
  logic [9:0]            r_leds;
  logic [13:0]           r_left;
  logic [13:0]           r_right;

  // Press pulse is registered so it appears 3 cycles after the pin falls
  assign w_fall = r_sync3 & ~r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= advance;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_press <= w_fall;
    end
  end

  assign w_rd_ok = (mem_rdata == f_pattern(r_pass, r_idx));

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_wait_nxt     = r_wait;
    w_pass_nxt     = r_pass;
    w_err_cnt_nxt  = r_err_cnt;
    w_err_flag_nxt = r_err_flag;
    w_done_nxt     = r_done;
    case (r_state)
      S_IDLE: begin
        if (r_press) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = 6'd0;
          w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = 6'd0;
`ifdef READBACK_CHECK_EN
          w_state_nxt = S_RD_ADDR;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_idx_nxt = r_idx + 6'd1;
        end
      end
      S_RD_ADDR: begin
        if (READ_LATENCY <= 1) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_RD_WAIT;
          w_wait_nxt  = WAIT_LOAD;
        end
      end
      S_RD_WAIT: begin
        if (r_wait == 2'd0) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      S_CHECK: begin
        if (!w_rd_ok) begin
          w_err_flag_nxt = 1'b1;
          // saturate rather than wrap so a long run of errors stays visible
          if (r_err_cnt != 8'hFF) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          end else begin
            w_err_cnt_nxt = r_err_cnt;
          end
        end else begin
          w_err_flag_nxt = r_err_flag;
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 6'd1;
          w_state_nxt = S_RD_ADDR;
        end
      end
      S_DONE: begin
        w_pass_nxt  = r_pass + 8'd1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_we_nxt = (w_state_nxt == S_WRITE);
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 6'd0;
      r_wait      <= 2'd0;
      r_pass      <= 8'd0;
      r_err_cnt   <= 8'd0;
      r_err_flag  <= 1'b0;
      r_done      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      r_mem_wdata <= '0;
      r_leds      <= 10'd0;
      r_left      <= 14'h2040;
      r_right     <= 14'h2040;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wait      <= w_wait_nxt;
      r_pass      <= w_pass_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_err_flag  <= w_err_flag_nxt;
      r_done      <= w_done_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w_idx_nxt);
      r_mem_wdata <= w_we_nxt ? f_pattern(w_pass_nxt, w_idx_nxt) : '0;
      r_leds      <= {w_idx_nxt, w_we_nxt, w_err_flag_nxt, w_done_nxt,
                      (w_state_nxt != S_IDLE)};
      r_left      <= {f_seg(w_pass_nxt[7:4]), f_seg(w_pass_nxt[3:0])};
      r_right     <= {f_seg(w_err_cnt_nxt[7:4]), f_seg(w_err_cnt_nxt[3:0])};
    end
  end

  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign mem_we           = r_mem_we;
  assign leds             = r_leds;
  assign left_7_seg_pair  = r_left;
  assign right_7_seg_pair = r_right;

endmodule
